// File: rtl/regfile_sb.sv
// Decode-stage register file: combinational read ports with write-through bypass,
// a per-register busy scoreboard for the hazard unit, and a synchronised trigger that sets TRIG_REG.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int TRIG_REG = 5,
    parameter int OUT_REG  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      busy_o,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic                trigger,
    output logic [XLEN-1:0]     a0,
    output logic                sb_err
);

    localparam int NREGS = 2**AW;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             s1, s2, s3;
    logic             trig_pulse;
    logic             issue_hit;
    logic             issue_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= trigger;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign trig_pulse = s2 & ~s3;

    // The trigger write comes last so it overrides a same-cycle writeback to TRIG_REG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (we && waddr != '0) regs[waddr] <= wdata;
            if (trig_pulse && TRIG_REG != 0) regs[TRIG_REG] <= XLEN'(1);
        end
    end

    assign issue_hit = issue_valid && (issue_rd != '0);
    assign issue_clr = we && (waddr == issue_rd);

    // Set after clear: a new producer supersedes the retiring one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            if (we) busy[waddr] <= 1'b0;
            if (issue_hit) busy[issue_rd] <= 1'b1;
            if (issue_hit && busy[issue_rd] && !issue_clr) sb_err <= 1'b1;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;

        assign ra  = raddr[p*AW +: AW];
        assign hit = we && (waddr == ra);

        assign rdata[p*XLEN +: XLEN] =
            (ra == '0)                            ? '0 :
            (trig_pulse && ra == AW'(TRIG_REG))   ? XLEN'(1) :
            hit                                   ? wdata :
                                                    regs[ra];

        assign busy_o[p] = busy[ra] & ~hit;
    end

    assign a0 = regs[OUT_REG];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations are queued as stimulus is applied
// and popped against the DUT outputs once they settle in the same cycle.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  busy_o;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        trigger;
    logic [31:0] a0;
    logic        sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];

    localparam int RD0 = 0, RD1 = 1, A0 = 2, BUSY = 3, ERR = 4;

    regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .busy_o(busy_o),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .trigger(trigger), .a0(a0), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            RD0:     return rdata[31:0];
            RD1:     return rdata[63:32];
            A0:      return a0;
            BUSY:    return {30'b0, busy_o};
            default: return {31'b0, sb_err};
        endcase
    endfunction

    task automatic expect_out(input int sel, input string tag, input logic [31:0] v);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        issue_valid = 1'b0; issue_rd = '0; trigger = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Populate state, then reset asynchronously mid-run
        we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; raddr = {5'd0, 5'd3};
        expect_out(RD0, "pre_rst_rd3", 32'hDEADBEEF);
        drain();
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick(); tick();
        issue_valid = 1'b0;
        expect_out(BUSY, "pre_rst_busy", 32'd1);
        expect_out(ERR,  "pre_rst_err",  32'd1);
        drain();
        rst = 1'b1;
        expect_out(RD0,  "rst_rd3",  32'd0);
        expect_out(RD1,  "rst_rd0",  32'd0);
        expect_out(A0,   "rst_a0",   32'd0);
        expect_out(BUSY, "rst_busy", 32'd0);
        expect_out(ERR,  "rst_err",  32'd0);
        drain();
        tick();
        rst = 1'b0;
        tick();

        // Register 0 ignores writes, including the bypass
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr = {5'd0, 5'd0};
        expect_out(RD0, "r0_bypass", 32'd0);
        drain();
        tick();
        we = 1'b0;
        expect_out(RD0, "r0_after", 32'd0);
        expect_out(RD1, "r0_after_p1", 32'd0);
        drain();

        // Write-through bypass on both ports
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd7};
        expect_out(RD0, "byp_p0", 32'hA5A5A5A5);
        expect_out(RD1, "byp_p1", 32'hA5A5A5A5);
        expect_out(A0,  "byp_a0", 32'd0);
        drain();
        tick();
        we = 1'b0;
        expect_out(RD0, "stor_p0", 32'hA5A5A5A5);
        expect_out(RD1, "stor_p1", 32'hA5A5A5A5);
        expect_out(A0,  "stor_a0", 32'd0);
        drain();

        // Scoreboard set, combinational hide on writeback, clear
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0; raddr = {5'd7, 5'd9};
        expect_out(BUSY, "sb_busy", 32'd1);
        drain();
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        expect_out(BUSY, "sb_wb_busy", 32'd0);
        expect_out(RD0,  "sb_wb_data", 32'h99);
        drain();
        tick();
        we = 1'b0;
        expect_out(BUSY, "sb_cleared", 32'd0);
        drain();
        issue_valid = 1'b1; issue_rd = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'h77;
        tick();
        issue_valid = 1'b0; we = 1'b0;
        expect_out(BUSY, "sb_set_wins", 32'd1);
        expect_out(RD0,  "sb_set_wins_data", 32'h77);
        expect_out(ERR,  "sb_no_err", 32'd0);
        drain();
        we = 1'b1; waddr = 5'd9; wdata = 32'h78;
        tick();
        we = 1'b0;

        // Double issue without writeback sets the sticky error
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        expect_out(ERR, "err_first", 32'd0);
        drain();
        tick();
        issue_valid = 1'b0;
        expect_out(ERR, "err_second", 32'd1);
        drain();
        we = 1'b1; waddr = 5'd4; wdata = 32'h4;
        tick();
        we = 1'b0; raddr = {5'd7, 5'd4};
        expect_out(ERR,  "err_sticky", 32'd1);
        expect_out(BUSY, "err_busy_clr", 32'd0);
        drain();

        // Trigger raised before edge N, held: one pulse in cycle N+1
        trigger = 1'b1; raddr = {5'd7, 5'd5};
        expect_out(RD0, "trg_pre", 32'd0);
        drain();
        tick();
        expect_out(RD0, "trg_edgeN", 32'd0);
        drain();
        tick();
        we = 1'b1; waddr = 5'd5; wdata = 32'hFF;
        expect_out(RD0, "trg_pulse_rd", 32'd1);
        drain();
        tick();
        we = 1'b0;
        expect_out(RD0, "trg_stor", 32'd1);
        drain();
        we = 1'b1; waddr = 5'd5; wdata = 32'h33;
        expect_out(RD0, "trg_rewrite_byp", 32'h33);
        drain();
        tick();
        we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            expect_out(RD0, $sformatf("trg_single_%0d", i), 32'h33);
            drain();
            tick();
        end
        trigger = 1'b0;

        // a0 follows storage of register 10 only after the write edge
        we = 1'b1; waddr = 5'd10; wdata = 32'h55; raddr = {5'd10, 5'd0};
        expect_out(A0,  "a0_before", 32'd0);
        expect_out(RD1, "a0_byp_rd", 32'h55);
        drain();
        tick();
        we = 1'b0;
        expect_out(A0,  "a0_after", 32'h55);
        expect_out(RD1, "a0_stor_rd", 32'h55);
        drain();
        tick();
        expect_out(A0, "a0_hold", 32'h55);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
